// File: rtl/anim_pkg.sv
// Shared definitions for the Simon animation sequencer.
//   ANIM_*      : 2-bit animation mode codes. The game FSM uses these to select an animation.
//   anim_state_e: sequencer state encoding (idle / running / finished).
package anim_pkg;

    localparam logic [1:0] ANIM_WIN   = 2'd0;
    localparam logic [1:0] ANIM_LOSE  = 2'd1;
    localparam logic [1:0] ANIM_CHASE = 2'd2;
    localparam logic [1:0] ANIM_FLASH = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } anim_state_e;

endpackage

// File: rtl/anim_pattern_gen.sv
// Combinational lamp/sound map for one animation step.
// Ports:
//   i_run     : high while the sequencer is running; both outputs are 0 otherwise
//   i_mode    : animation mode (anim_pkg::ANIM_*)
//   i_step    : current step index
//   i_last    : index of the final step
//   i_cidx    : chase lamp index, always step mod N_LIGHTS
//   i_pattern : latched FLASH lamp pattern
//   i_tone    : latched FLASH sound code
//   o_lights  : lamp drive
//   o_sound   : sound code (0 = silence)
module anim_pattern_gen
    import anim_pkg::*;
#(
    parameter int unsigned N_LIGHTS = 4,
    parameter int unsigned STEP_W   = 4,
    parameter int unsigned SOUND_W  = 4,
    parameter int unsigned CIDX_W   = 2
) (
    input  logic                i_run,
    input  logic [1:0]          i_mode,
    input  logic [STEP_W-1:0]   i_step,
    input  logic [STEP_W-1:0]   i_last,
    input  logic [CIDX_W-1:0]   i_cidx,
    input  logic [N_LIGHTS-1:0] i_pattern,
    input  logic [SOUND_W-1:0]  i_tone,
    output logic [N_LIGHTS-1:0] o_lights,
    output logic [SOUND_W-1:0]  o_sound
);

    localparam int unsigned SMAX = 2 ** SOUND_W - 1;

    logic [STEP_W-1:0] w_tri;
    logic [31:0]       w_tri_inc;
    logic [31:0]       w_cidx_inc;

    // WIN pitch rises to the midpoint of the animation and falls back symmetrically.
    always_comb begin
        if (i_step <= (i_last >> 1)) begin
            w_tri = i_step;
        end else begin
            w_tri = i_last - i_step;
        end
        w_tri_inc  = 32'(w_tri) + 32'd1;
        w_cidx_inc = 32'(i_cidx) + 32'd1;
    end

    always_comb begin
        o_lights = '0;
        o_sound  = '0;
        if (i_run) begin
            unique case (i_mode)
                ANIM_WIN: begin
                    for (int i = 0; i < N_LIGHTS; i++) begin
                        o_lights[i] = (i[0] == i_step[0]);
                    end
                    o_sound = (w_tri_inc > SMAX) ? SOUND_W'(SMAX) : SOUND_W'(w_tri_inc);
                end
                ANIM_LOSE: begin
                    o_lights = {N_LIGHTS{i_step[0]}};
                    o_sound  = (32'(i_step) >= SMAX) ? SOUND_W'(1)
                                                     : SOUND_W'(SMAX - 32'(i_step));
                end
                ANIM_CHASE: begin
                    o_lights = N_LIGHTS'(1) << i_cidx;
                    o_sound  = (w_cidx_inc > SMAX) ? SOUND_W'(SMAX) : SOUND_W'(w_cidx_inc);
                end
                ANIM_FLASH: begin
                    if (!i_step[0]) begin
                        o_lights = i_pattern;
                        o_sound  = i_tone;
                    end
                end
                default: begin
                    o_lights = '0;
                    o_sound  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/anim_player.sv
// Light/sound animation sequencer for the Simon game. A start latches mode, length,
// pattern and tone; each 'next' tick then advances one step until the last step ends.
// State changes on the falling clock edge; reset is asynchronous and active-low.
// Ports:
//   i_clk     : system clock (falling-edge active)
//   i_rst_n   : asynchronous active-low reset
//   i_start   : begin an animation from IDLE or DONE (ignored while running)
//   i_abort   : return to IDLE; overrides start and next
//   i_next    : one-cycle step tick
//   i_mode    : anim_pkg::ANIM_* mode, latched on start
//   i_len     : step count, latched on start (0 behaves as 1)
//   i_pattern : FLASH lamp pattern, latched on start
//   i_tone    : FLASH sound code, latched on start
//   o_lights  : lamp drive
//   o_sound   : sound code
//   o_busy    : animation running
//   o_done    : animation finished, waiting for restart or abort
module anim_player
    import anim_pkg::*;
#(
    parameter int unsigned N_LIGHTS = 4,
    parameter int unsigned STEP_W   = 4,
    parameter int unsigned SOUND_W  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic                i_next,
    input  logic [1:0]          i_mode,
    input  logic [STEP_W-1:0]   i_len,
    input  logic [N_LIGHTS-1:0] i_pattern,
    input  logic [SOUND_W-1:0]  i_tone,
    output logic [N_LIGHTS-1:0] o_lights,
    output logic [SOUND_W-1:0]  o_sound,
    output logic                o_busy,
    output logic                o_done
);

    localparam int unsigned CIDX_W = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1;

    anim_state_e         r_state;
    anim_state_e         w_state_next;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   r_last;
    logic [CIDX_W-1:0]   r_cidx;
    logic [1:0]          r_mode;
    logic [N_LIGHTS-1:0] r_pattern;
    logic [SOUND_W-1:0]  r_tone;

    logic w_load;
    logic w_adv;
    logic w_at_last;
    logic w_run;

    assign w_at_last = (r_step == r_last);
    // Start is honoured only outside RUN, so a running animation cannot be retriggered.
    assign w_load    = !i_abort && i_start && (r_state != ST_RUN);
    assign w_adv     = !i_abort && i_next && (r_state == ST_RUN) && !w_at_last;

    // State register
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (i_abort) begin
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: if (i_start) w_state_next = ST_RUN;
                ST_RUN:  if (i_next && w_at_last) w_state_next = ST_DONE;
                ST_DONE: if (i_start) w_state_next = ST_RUN;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Step/chase counters and latched operands
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step    <= '0;
            r_last    <= '0;
            r_cidx    <= '0;
            r_mode    <= '0;
            r_pattern <= '0;
            r_tone    <= '0;
        end else if (w_load) begin
            r_step    <= '0;
            r_cidx    <= '0;
            r_mode    <= i_mode;
            // Store the final step index directly; a zero length runs a single step.
            r_last    <= (i_len == '0) ? '0 : i_len - STEP_W'(1);
            r_pattern <= i_pattern;
            r_tone    <= i_tone;
        end else if (w_adv) begin
            r_step <= r_step + STEP_W'(1);
            r_cidx <= (r_cidx == CIDX_W'(N_LIGHTS - 1)) ? '0 : r_cidx + CIDX_W'(1);
        end
    end

    // Output logic
    always_comb begin
        w_run  = (r_state == ST_RUN);
        o_busy = w_run;
        o_done = (r_state == ST_DONE);
    end

    anim_pattern_gen #(
        .N_LIGHTS (N_LIGHTS),
        .STEP_W   (STEP_W),
        .SOUND_W  (SOUND_W),
        .CIDX_W   (CIDX_W)
    ) u_pattern_gen (
        .i_run     (w_run),
        .i_mode    (r_mode),
        .i_step    (r_step),
        .i_last    (r_last),
        .i_cidx    (r_cidx),
        .i_pattern (r_pattern),
        .i_tone    (r_tone),
        .o_lights  (o_lights),
        .o_sound   (o_sound)
    );

endmodule
